song_note_feeder: RTL and testbench

Prefetching note source for learn mode. Walks one song segment of a synchronous song ROM and presents each stored note word as a first-word-fall-through stream on `data_out`/`output_ready`. The learn-mode comparator pops entries with `read_en`. Sits directly upstream of the learn-mode comparator and directly downstream of the song ROM.

---
 rtl/song_note_feeder_if.sv | 26 ++
 rtl/song_note_feeder.sv | 140 ++++++++++++++
 tb/tb_song_note_feeder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/song_note_feeder_if.sv
// Bundles the song-ROM side and the comparator-side stream of song_note_feeder.
// The master modport is the feeder; the slave modport is its environment.
interface song_note_feeder_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [1:0]        song_sel;
   logic              read_en;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [10:0]       rom_data;
   logic [9:0]        data_out;
   logic              output_ready;
   logic              song_done;
   logic [ADDR_W-3:0] note_index;

   modport master (
      input  start, song_sel, read_en, rom_data,
      output rom_en, rom_addr, data_out, output_ready, song_done, note_index
   );

   modport slave (
      output start, song_sel, read_en, rom_data,
      input  rom_en, rom_addr, data_out, output_ready, song_done, note_index
   );
endinterface

// File: rtl/song_note_feeder.sv
// Walks one segment of a synchronous song ROM and presents the stored note words
// as a first-word-fall-through stream through a 2-entry buffer.
module song_note_feeder #(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   song_note_feeder_if.master  bus
);
   localparam int OFF_W = ADDR_W - 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [OFF_W-1:0]  offset_q, offset_d;
   logic [OFF_W-1:0]  note_index_q, note_index_d;
   logic              guard_q, guard_d;
   logic              rom_en_q, rom_en_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rv_q, rv_d;
   logic [9:0]        head_q, head_d, tail_q, tail_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              push, pop, marker;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      offset_d     = offset_q;
      note_index_d = note_index_q;
      guard_d      = guard_q;
      rom_en_d     = 1'b0;
      rom_addr_d   = rom_addr_q;
      head_d       = head_q;
      tail_d       = tail_q;
      cnt_d        = cnt_q;
      // A word is on rom_data the cycle after its strobe; start orphans whatever is outstanding.
      rv_d         = rom_en_q & ~bus.start;
      marker       = rv_q & bus.rom_data[10];
      push         = rv_q & ~bus.rom_data[10] & (state_q == RUN) & ~bus.start;
      pop          = bus.read_en & ready_q & ~bus.start;

      if (bus.start) begin
         state_d      = RUN;
         sel_d        = bus.song_sel;
         offset_d     = OFF_W'(1);
         note_index_d = '0;
         cnt_d        = 2'd0;
         guard_d      = 1'b0;
         rom_en_d     = 1'b1;
         rom_addr_d   = {bus.song_sel, {OFF_W{1'b0}}};
      end else begin
         note_index_d = note_index_q + OFF_W'(pop);

         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) head_d = bus.rom_data[9:0];
               else               tail_d = bus.rom_data[9:0];
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               head_d = tail_q;
               cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = bus.rom_data[9:0];
               end else begin
                  head_d = bus.rom_data[9:0];
               end
            end
            default: ;
         endcase

         // The guard word is the last one returning once no newer strobe is pending.
         case (state_q)
            RUN:     if (marker || (guard_q && rv_q && !rom_en_q)) state_d = DRAIN;
            DRAIN:   if ((cnt_d == 2'd0) && !rom_en_q) state_d = DONE;
            default: ;
         endcase

         // Issue only if every outstanding word is guaranteed a buffer slot without relying on future pops.
         if ((state_d == RUN) && !guard_q &&
             (({1'b0, cnt_d} + {2'b00, rom_en_q}) < 3'd2)) begin
            rom_en_d   = 1'b1;
            rom_addr_d = {sel_q, offset_q};
            offset_d   = offset_q + OFF_W'(1);
            guard_d    = &offset_q;
         end
      end

      ready_d = (cnt_d != 2'd0);
      done_d  = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the two buffer words are plain flops and are reset too, keeping data_out at 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= 2'd0;
         offset_q     <= '0;
         note_index_q <= '0;
         guard_q      <= 1'b0;
         rom_en_q     <= 1'b0;
         rom_addr_q   <= '0;
         rv_q         <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         cnt_q        <= 2'd0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         offset_q     <= offset_d;
         note_index_q <= note_index_d;
         guard_q      <= guard_d;
         rom_en_q     <= rom_en_d;
         rom_addr_q   <= rom_addr_d;
         rv_q         <= rv_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
      end
   end

   assign bus.rom_en       = rom_en_q;
   assign bus.rom_addr     = rom_addr_q;
   assign bus.data_out     = head_q;
   assign bus.output_ready = ready_q;
   assign bus.song_done    = done_q;
   assign bus.note_index   = note_index_q;
endmodule

// File: tb/tb_song_note_feeder.sv
// Scoreboard bench for song_note_feeder: stimulus loads the expected note queue,
// a negedge monitor checks each popped word and its index against it.
module tb_song_note_feeder;
   localparam int ADDR_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   song_note_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   song_note_feeder #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Synchronous ROM model: word valid the cycle after the strobe.
   logic [10:0] rom [256];
   logic [10:0] rom_q = '0;
   always @(posedge clk) if (bus.rom_en) rom_q <= rom[bus.rom_addr];
   assign bus.rom_data = rom_q;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q [$];
   int         exp_idx = 0;
   int         issue_cnt = 0;
   int         bad_addr = 0;
   logic [7:0] addr_log [$];
   logic [1:0] cur_sel = 2'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a pop happens at the next rising edge when ready and read_en are both high.
   always @(negedge clk) begin
      if (rst_n && bus.output_ready && bus.read_en && !bus.start) begin
         check("pop_expected_avail", 32'(exp_q.size() != 0), 32'd1);
         check("done_low_while_popping", 32'(bus.song_done), 32'd0);
         if (exp_q.size() != 0) begin
            check("pop_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            check("pop_index", 32'(bus.note_index), 32'(exp_idx % 64));
         end
         exp_idx++;
      end
   end

   // ROM strobe log: counts issues and flags any address outside the selected segment.
   always @(negedge clk) begin
      if (bus.rom_en) begin
         issue_cnt++;
         addr_log.push_back(bus.rom_addr);
         if (bus.rom_addr[7:6] !== cur_sel) bad_addr++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_song(input logic [1:0] sel);
      logic [10:0] w;
      exp_q.delete();
      for (int o = 0; o < 64; o++) begin
         w = rom[{sel, 6'(o)}];
         if (w[10]) break;
         exp_q.push_back(w[9:0]);
      end
      exp_idx      = 0;
      cur_sel      = sel;
      bus.song_sel = sel;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      issue_cnt = 0;
      bad_addr  = 0;
      addr_log.delete();
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!bus.song_done && n < budget) begin
         tick();
         n++;
      end
      check({name, "_done"}, 32'(bus.song_done), 32'd1);
      check({name, "_all_popped"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rom_en"},       32'(bus.rom_en),       32'd0);
      check({name, "_rom_addr"},     32'(bus.rom_addr),     32'd0);
      check({name, "_data_out"},     32'(bus.data_out),     32'd0);
      check({name, "_output_ready"}, 32'(bus.output_ready), 32'd0);
      check({name, "_song_done"},    32'(bus.song_done),    32'd0);
      check({name, "_note_index"},   32'(bus.note_index),   32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 11'h400;
      for (int i = 0; i < 64; i++)  rom[i] = {1'b0, 10'(i * 37 + 5)};
      rom[8'h40] = 11'h041; rom[8'h41] = 11'h102; rom[8'h42] = 11'h400;
      rom[8'h80] = 11'h2A1; rom[8'h81] = 11'h155; rom[8'h82] = 11'h0F3;
      rom[8'hC0] = 11'h301; rom[8'hC1] = 11'h0F2; rom[8'hC2] = 11'h2C3;
      rom[8'hC3] = 11'h1B4; rom[8'hC4] = 11'h3A5;

      bus.start    = 1'b0;
      bus.song_sel = 2'd0;
      bus.read_en  = 1'b0;

      // Reset state, then a priming pop while idle must be ignored.
      tick(2);
      check_all_zero("reset");
      #2 rst_n = 1'b1;
      tick();
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      tick();
      check("prime_note_index",   32'(bus.note_index),   32'd0);
      check("prime_output_ready", 32'(bus.output_ready), 32'd0);
      check("prime_rom_en",       32'(bus.rom_en),       32'd0);

      // Basic song in segment 1: two notes then a marker.
      start_song(2'd1);
      check("basic_e0_rom_en",   32'(bus.rom_en),       32'd1);
      check("basic_e0_rom_addr", 32'(bus.rom_addr),     32'h40);
      check("basic_e0_ready",    32'(bus.output_ready), 32'd0);
      tick();
      check("basic_e1_rom_addr", 32'(bus.rom_addr),     32'h41);
      check("basic_e1_ready",    32'(bus.output_ready), 32'd0);
      tick();
      check("basic_e2_ready",    32'(bus.output_ready), 32'd1);
      check("basic_e2_data",     32'(bus.data_out),     32'h041);
      bus.read_en = 1'b1;
      tick();
      check("basic_e3_ready",    32'(bus.output_ready), 32'd1);
      check("basic_e3_data",     32'(bus.data_out),     32'h102);
      wait_done("basic", 50);
      check("basic_note_index", 32'(bus.note_index), 32'd2);
      check("basic_addr_log_len", 32'(addr_log.size() >= 3), 32'd1);
      if (addr_log.size() >= 3) begin
         check("basic_addr0", 32'(addr_log[0]), 32'h40);
         check("basic_addr1", 32'(addr_log[1]), 32'h41);
         check("basic_addr2", 32'(addr_log[2]), 32'h42);
      end
      bus.read_en = 1'b0;

      // Back-pressure: no pops for 10 cycles fills exactly two entries.
      start_song(2'd3);
      tick(3);
      check("bp_data_early", 32'(bus.data_out), 32'h301);
      tick(7);
      check("bp_issue_cnt", 32'(issue_cnt),        32'd2);
      check("bp_rom_en",    32'(bus.rom_en),       32'd0);
      check("bp_ready",     32'(bus.output_ready), 32'd1);
      check("bp_data_late", 32'(bus.data_out),     32'h301);
      bus.read_en = 1'b1;
      wait_done("bp", 100);
      check("bp_note_index", 32'(bus.note_index), 32'd5);

      // Streaming with read_en held high.
      start_song(2'd3);
      wait_done("stream", 100);
      check("stream_note_index", 32'(bus.note_index), 32'd5);
      check("stream_bad_addr",   32'(bad_addr),       32'd0);

      // Restart into segment 2 while a read is in flight and read_en is high.
      start_song(2'd3);
      tick(3);
      start_song(2'd2);
      check("restart_note_index", 32'(bus.note_index),   32'd0);
      check("restart_ready",      32'(bus.output_ready), 32'd0);
      check("restart_rom_addr",   32'(bus.rom_addr),     32'h80);
      wait_done("restart", 100);
      check("restart_final_index", 32'(bus.note_index), 32'd3);

      // Segment guard: segment 0 holds 64 notes and no marker.
      start_song(2'd0);
      wait_done("guard", 2000);
      check("guard_issue_cnt",  32'(issue_cnt),      32'd64);
      check("guard_bad_addr",   32'(bad_addr),       32'd0);
      check("guard_note_index", 32'(bus.note_index), 32'd0);

      // Asynchronous reset mid-song, then a priming pop after release.
      start_song(2'd0);
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(2);
      check("post_reset_note_index", 32'(bus.note_index),   32'd0);
      check("post_reset_ready",      32'(bus.output_ready), 32'd0);
      check("post_reset_rom_en",     32'(bus.rom_en),       32'd0);
      check("post_reset_data",       32'(bus.data_out),     32'd0);
      bus.read_en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
